// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM stream reader: FSM state encoding and the
// helper that sizes the word-count field (one bit wider than the address).
package bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // A full-memory command needs one more bit than the address width.
    function automatic int len_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// BRAM read port plus the outgoing valid/ready word stream, bundled so the
// reader (master) and the BRAM/consumer side (slave) share one connection.
interface bram_stream_reader_if #(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32
);
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
    logic [BRAM_DATA_WIDTH-1:0] rd_data;
    logic [BRAM_DATA_WIDTH-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );
endinterface

// File: rtl/bram_stream_reader.sv
// Walks a block of BRAM addresses and streams each word out at full rate.
// Define BRAM_READER_STRIDE_EN to add a per-command address stride input.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int BRAM_ADDR_WIDTH = 6,
    parameter int BRAM_DATA_WIDTH = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      start,
    input  logic [BRAM_ADDR_WIDTH-1:0]                base_addr,
    input  logic [len_width(BRAM_ADDR_WIDTH)-1:0]     length,
`ifdef BRAM_READER_STRIDE_EN
    input  logic [BRAM_ADDR_WIDTH-1:0]                stride,
`endif
    output logic                                      busy,
    output logic                                      done,
    bram_stream_reader_if.master                      bus
);

    localparam int LW = len_width(BRAM_ADDR_WIDTH);
    localparam logic [LW-1:0] LEN_ONE = LW'(1);

    state_e                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LW-1:0]              remaining_q, remaining_d;
    logic [BRAM_DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       out_last_q, out_last_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [BRAM_ADDR_WIDTH-1:0] step;
    logic                       fire;

`ifdef BRAM_READER_STRIDE_EN
    logic [BRAM_ADDR_WIDTH-1:0] stride_q, stride_d;

    always_comb begin
        stride_d = stride_q;
        if (state_q == IDLE && start) begin
            stride_d = stride;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stride_q <= '0;
        end else begin
            stride_q <= stride_d;
        end
    end

    assign step = stride_q;
`else
    assign step = BRAM_ADDR_WIDTH'(1);
`endif

    // The output register may load whenever it is empty or being drained.
    assign fire = !out_valid_q || bus.out_ready;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_addr_d   = base_addr;
                    remaining_d = length;
                    busy_d      = 1'b1;
                    state_d     = (length == '0) ? FLUSH : READ;
                end
            end
            READ: begin
                if (fire) begin
                    out_data_d  = bus.rd_data;
                    out_valid_d = 1'b1;
                    out_last_d  = (remaining_q == LEN_ONE);
                    rd_addr_d   = rd_addr_q + step;
                    remaining_d = remaining_q - LEN_ONE;
                    if (remaining_q == LEN_ONE) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // An empty register (zero-length command) completes immediately.
                if (fire) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.rd_addr   = rd_addr_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: BRAM model, stalls, wrap, zero length,
// ignored restart, mid-command reset and (with BRAM_READER_STRIDE_EN) stride.
module tb_bram_stream_reader;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
`ifdef BRAM_READER_STRIDE_EN
    logic [AW-1:0] stride = 6'd1;
`endif

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_assert = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int done_count = 0;
    int hs_mark;
    int done_mark;

    bram_stream_reader_if #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) bus ();

    bram_stream_reader #(.BRAM_ADDR_WIDTH(AW), .BRAM_DATA_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
`ifdef BRAM_READER_STRIDE_EN
        .stride    (stride),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    assign bus.rd_data = mem[bus.rd_addr];

    always @(posedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) hs_count++;
        if (!reset && done) done_count++;
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [DW-1:0] exp_data, input logic exp_last);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, ".data"},  64'(bus.out_data),  64'(exp_data));
        chk({tag, ".last"},  64'(bus.out_last),  64'(exp_last));
        $display("word %s data=%08h last=%0b", tag, bus.out_data, bus.out_last);
    endtask

    task automatic chk_idle_done(input string tag);
        chk({tag, ".valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".done"},  64'(done), 64'd1);
        chk({tag, ".busy"},  64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [AW-1:0] b, input logic [AW:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        step();
        start     = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hDEAD_0000 + i;
        bus.out_ready = 1'b1;

        // Reset state
        step(); step();
        chk("rst.rd_addr", 64'(bus.rd_addr), 64'd0);
        chk("rst.out_data", 64'(bus.out_data), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_last", 64'(bus.out_last), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        reset = 1'b0;
        step();

        // Basic 3-word read from address 4
        hs_mark = hs_count;
        issue(6'd4, 7'd3);
        chk("t1.accept.busy", 64'(busy), 64'd1);
        chk("t1.accept.valid", 64'(bus.out_valid), 64'd0);
        chk("t1.accept.rd_addr", 64'(bus.rd_addr), 64'd4);
        step(); chk_word("t1.w0", 32'hDEAD_0004, 1'b0); chk("t1.w0.busy", 64'(busy), 64'd1);
        step(); chk_word("t1.w1", 32'hDEAD_0005, 1'b0); chk("t1.w1.busy", 64'(busy), 64'd1);
        step(); chk_word("t1.w2", 32'hDEAD_0006, 1'b1); chk("t1.w2.busy", 64'(busy), 64'd1);
        chk("t1.rd_addr_after", 64'(bus.rd_addr), 64'd7);
        step(); chk_idle_done("t1.end");
        step(); chk("t1.done_pulse", 64'(done), 64'd0);
        chk("t1.handshakes", 64'(hs_count - hs_mark), 64'd3);

        // Address wrap from 62
        hs_mark = hs_count;
        issue(6'd62, 7'd4);
        step(); chk_word("t2.w0", 32'hDEAD_003E, 1'b0);
        step(); chk_word("t2.w1", 32'hDEAD_003F, 1'b0);
        step(); chk_word("t2.w2", 32'hDEAD_0000, 1'b0);
        step(); chk_word("t2.w3", 32'hDEAD_0001, 1'b1);
        chk("t2.rd_addr_wrap", 64'(bus.rd_addr), 64'd2);
        step(); chk_idle_done("t2.end");
        chk("t2.handshakes", 64'(hs_count - hs_mark), 64'd4);
        step();

        // Consumer stall while the first word is valid
        hs_mark = hs_count;
        bus.out_ready = 1'b0;
        issue(6'd10, 7'd3);
        step(); chk_word("t3.w0", 32'hDEAD_000A, 1'b0);
        for (int s = 0; s < 3; s++) begin
            step(); chk_word("t3.stall", 32'hDEAD_000A, 1'b0);
            chk("t3.stall.rd_addr", 64'(bus.rd_addr), 64'd11);
        end
        bus.out_ready = 1'b1;
        step(); chk_word("t3.w1", 32'hDEAD_000B, 1'b0);
        step(); chk_word("t3.w2", 32'hDEAD_000C, 1'b1);
        step(); chk_idle_done("t3.end");
        chk("t3.handshakes", 64'(hs_count - hs_mark), 64'd3);
        step();

        // Zero-length command
        hs_mark = hs_count;
        issue(6'd20, 7'd0);
        chk("t4.accept.busy", 64'(busy), 64'd1);
        chk("t4.accept.done", 64'(done), 64'd0);
        chk("t4.accept.valid", 64'(bus.out_valid), 64'd0);
        step(); chk_idle_done("t4.end");
        step(); chk("t4.done_pulse", 64'(done), 64'd0);
        chk("t4.handshakes", 64'(hs_count - hs_mark), 64'd0);

        // Start while busy is ignored
        hs_mark = hs_count;
        done_mark = done_count;
        issue(6'd0, 7'd5);
        start = 1'b1; base_addr = 6'd30; length = 7'd2;
        step(); start = 1'b0;
        chk_word("t5.w0", 32'hDEAD_0000, 1'b0);
        step(); chk_word("t5.w1", 32'hDEAD_0001, 1'b0);
        step(); chk_word("t5.w2", 32'hDEAD_0002, 1'b0);
        step(); chk_word("t5.w3", 32'hDEAD_0003, 1'b0);
        step(); chk_word("t5.w4", 32'hDEAD_0004, 1'b1);
        step(); chk_idle_done("t5.end");
        step(); step();
        chk("t5.handshakes", 64'(hs_count - hs_mark), 64'd5);
        chk("t5.done_count", 64'(done_count - done_mark), 64'd1);
        chk("t5.idle.busy", 64'(busy), 64'd0);

        // Reset in the middle of an 8-word command
        done_mark = done_count;
        issue(6'd40, 7'd8);
        step(); chk_word("t6.w0", 32'hDEAD_0028, 1'b0);
        step(); chk_word("t6.w1", 32'hDEAD_0029, 1'b0);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t6.rst.valid", 64'(bus.out_valid), 64'd0);
        chk("t6.rst.busy", 64'(busy), 64'd0);
        chk("t6.rst.done", 64'(done), 64'd0);
        chk("t6.rst.rd_addr", 64'(bus.rd_addr), 64'd0);
        for (int s = 0; s < 4; s++) step();
        chk("t6.no_done", 64'(done_count - done_mark), 64'd0);
        chk("t6.idle.valid", 64'(bus.out_valid), 64'd0);
        issue(6'd50, 7'd2);
        step(); chk_word("t6.fresh.w0", 32'hDEAD_0032, 1'b0);
        step(); chk_word("t6.fresh.w1", 32'hDEAD_0033, 1'b1);
        step(); chk_idle_done("t6.fresh.end");
        step();

`ifdef BRAM_READER_STRIDE_EN
        // Strided read 1, 9, 17, 25
        stride = 6'd8;
        issue(6'd1, 7'd4);
        stride = 6'd1;
        step(); chk_word("t7.w0", 32'hDEAD_0001, 1'b0);
        step(); chk_word("t7.w1", 32'hDEAD_0009, 1'b0);
        step(); chk_word("t7.w2", 32'hDEAD_0011, 1'b0);
        step(); chk_word("t7.w3", 32'hDEAD_0019, 1'b1);
        chk("t7.rd_addr_after", 64'(bus.rd_addr), 64'd33);
        step(); chk_idle_done("t7.end");
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
